seg_scan_driver: RTL and testbench
==================================

Name: seg_scan_driver

Overview:
Time-multiplexed driver for an N-digit common-anode seven-segment display, used by the alarm clock's display path. It takes packed hex nibbles plus per-digit decimal-point, blank and blink controls, and scans one digit at a time onto a shared segment bus. It adds the following over the single-digit combinational decoder:
- tear-free frame-synchronous loading
- leading-zero suppression
- blinking
- anti-ghosting guard cycles

Parameters:
NUM_DIGITS, 4, digits scanned (legal 1..8)
REFRESH_DIV, 50000, clk cycles per digit slot (must exceed GUARD+1)
GUARD, 2, cycles at slot start with all anodes off
BLINK_DIV, 25000000, clk cycles per blink half-period
ACTIVE_LOW, 1, 1 = segments/anodes/dp driven low-true; 0 = high-true

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
digits_in  in  4*NUM_DIGITS  hex nibbles; [3:0] = digit 0 (rightmost, least significant)
dp_in  in  NUM_DIGITS  decimal point request per digit
blank_in  in  NUM_DIGITS  force digit dark
blink_in  in  NUM_DIGITS  digit blinks
lz_suppress  in  1  enable leading-zero suppression
load  in  1  one-cycle strobe capturing all *_in and lz_suppress into staging
seg_out  out  7  segments, bit0=a .. bit6=g
dp_out  out  1  decimal point
an_out  out  NUM_DIGITS  anode enables, at most one active
frame_done  out  1  one-cycle pulse when the scan wraps from last digit to 0

Behaviour:
- Reset: clk and rst_n as named above; reset is asynchronous assert, synchronous release.
- Reset state:
  - all outputs at inactive level: seg_out=7'h7F, dp_out=1, an_out=all ones (ACTIVE_LOW=1); frame_done=0
  - active and staging registers: digits=0, dp=0, blink=0, blank=all ones (display dark until first applied load)
  - pending=0, scan index=0, refresh count=0, blink count=0, blink phase=visible
- Refresh count runs 0..REFRESH_DIV-1.
  - At terminal count, index advances; NUM_DIGITS-1 wraps to 0.
  - On that wrap edge, frame_done=1 for exactly one cycle.
- All outputs are registered.
  - For refresh count < GUARD: an_out all inactive; seg_out and dp_out are still driven with the current digit's pattern.
  - Otherwise: an_out[index] active and all other anodes inactive.
- Segment table (active-low hex, bit0=a), digits 0..F: 40 79 24 30 19 12 02 78 00 10 08 03 46 21 06 0E. When ACTIVE_LOW=0, outputs are the bitwise inverse.
- Load:
  - load=1 copies the inputs to staging and sets pending.
  - At frame wrap with pending=1: staging copies to active and pending clears.
  - load coincident with wrap: incoming values go directly to active and pending clears.
  - Multiple loads within one frame: the last one wins.
- Leading-zero suppression (from active lz flag): digit i is dark if all digits NUM_DIGITS-1 down to i are zero. Digit 0 is never suppressed. dp is unaffected by suppression.
- Blink: the blink counter wraps at BLINK_DIV-1 and toggles phase. A digit with blink=1 is dark (segments and dp) during the hidden phase.
- Blank: blank=1 darkens the digit's segments and dp; it takes priority over everything else.
- Dark digit: the anode is still pulsed normally and seg/dp sit at their inactive level.
- Reset mid-scan: everything returns to the reset state immediately; the first frame_done follows NUM_DIGITS*REFRESH_DIV cycles after release.

Decomposition:
- Shared package seg_pkg:
  - SEG_ROM constant (16 x 7, active-low)
  - SEG_OFF constant
  - localparam helpers for counter widths via $clog2
- One sub-module seg_hex_decode: a combinational 4-to-7 nibble lookup with an ACTIVE_LOW parameter. It is instantiated once, on the muxed nibble.
- The top level holds the counters, staging/active registers, suppression and blink logic.

Test Plan:
1. Reset, NUM_DIGITS=4, REFRESH_DIV=8, GUARD=2, no load -> an_out stays 4'hF during guard; seg_out=7'h7F throughout; frame_done first pulses 32 cycles after release.
2. load digits=16'h1234 mid-frame -> no change until the next frame_done; then each slot shows 79/24/30/19 with the one-hot anode low on digits 3..0, and anodes stay off for cycles 0-1 of each slot.
3. digits=16'h0050, lz_suppress=1 -> digits 3 and 2 dark; digit 1 shows 12; digit 0 shows 40; with dp_in=4'b1000, dp_out=0 in slot 3.
4. blink_in=4'b0001, BLINK_DIV=16 -> digit 0 alternates 40/7F every 16 cycles; other digits are steady.
5. load pulsed in the same cycle as the wrap with 16'hABCD -> 08/03/46/21 appear in the very next frame; pending is clear.
6. Assert rst_n=0 mid-slot 2 -> outputs go inactive asynchronously; after release the scan restarts at digit 0 with the display dark.

Source files
------------

// File: rtl/seg_pkg.sv
// seg_pkg: constants shared by the seven-segment scan driver.
// Active-low hex segment ROM (bit0=a), dark pattern, counter width helper.
package seg_pkg;

  localparam logic [6:0] SEG_OFF = 7'h7F;

  localparam logic [15:0][6:0] SEG_ROM = {
    7'h0E, 7'h06, 7'h21, 7'h46,
    7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19,
    7'h30, 7'h24, 7'h79, 7'h40
  };

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/seg_hex_decode.sv
// seg_hex_decode: combinational hex nibble to seven-segment lookup.
// Ports: nib (hex digit in), seg (bit0=a, polarity set by ACTIVE_LOW).
module seg_hex_decode
  import seg_pkg::*;
#(
  parameter int ACTIVE_LOW = 1
) (
  input  logic [3:0] nib,
  output logic [6:0] seg
);

  assign seg = (ACTIVE_LOW != 0) ? SEG_ROM[nib] : ~SEG_ROM[nib];

endmodule

// File: rtl/seg_scan_driver.sv
// seg_scan_driver: multiplexed N-digit seven-segment driver with staging,
// lz suppression, blink, guard. Ports: *_in/lz_suppress/load in; seg/dp/an/frame_done out.
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 50000,
  parameter int GUARD       = 2,
  parameter int BLINK_DIV   = 25000000,
  parameter int ACTIVE_LOW  = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blank_in,
  input  logic [NUM_DIGITS-1:0]   blink_in,
  input  logic                    lz_suppress,
  input  logic                    load,
  output logic [6:0]              seg_out,
  output logic                    dp_out,
  output logic [NUM_DIGITS-1:0]   an_out,
  output logic                    frame_done
);

  localparam int N  = NUM_DIGITS;
  localparam int RW = cnt_w(REFRESH_DIV);
  localparam int IW = cnt_w(N);
  localparam int BW = cnt_w(BLINK_DIV);

  localparam logic       ON   = (ACTIVE_LOW != 0) ? 1'b0 : 1'b1;
  localparam logic [6:0] SOFF = ON ? ~SEG_OFF : SEG_OFF;

  localparam logic [RW-1:0] R_TC = RW'(REFRESH_DIV - 1);
  localparam logic [RW-1:0] R_GD = RW'(GUARD);
  localparam logic [IW-1:0] I_TC = IW'(N - 1);
  localparam logic [BW-1:0] B_TC = BW'(BLINK_DIV - 1);

  logic [RW-1:0] rcnt, rcnt_d;
  logic [IW-1:0] idx, idx_d;
  logic [BW-1:0] bcnt, bcnt_d;
  logic          hide, hide_d;
  logic          slot_end, wrap, bwrap;

  logic [4*N-1:0] act_dig, act_dig_d, stg_dig, stg_dig_d;
  logic [N-1:0]   act_dp, act_dp_d, stg_dp, stg_dp_d;
  logic [N-1:0]   act_bnk, act_bnk_d, stg_bnk, stg_bnk_d;
  logic [N-1:0]   act_blk, act_blk_d, stg_blk, stg_blk_d;
  logic           act_lz, act_lz_d, stg_lz, stg_lz_d;
  logic           pend, pend_d;

  logic [3:0]   nib;
  logic         zeros, sel_z, sel_dp, sel_bnk, sel_blk;
  logic         lz_dark, hard_dark;
  logic [6:0]   dec_seg, seg_d;
  logic         dp_d;
  logic [N-1:0] an_d;

  always_comb begin
    slot_end = (rcnt == R_TC);
    wrap     = slot_end && (idx == I_TC);
    rcnt_d   = slot_end ? '0 : rcnt + 1'b1;
    idx_d    = idx;
    if (slot_end) idx_d = wrap ? '0 : idx + 1'b1;
    bwrap    = (bcnt == B_TC);
    bcnt_d   = bwrap ? '0 : bcnt + 1'b1;
    hide_d   = hide ^ bwrap;
  end

  // Active set only changes on the frame wrap so a frame never tears.
  always_comb begin
    stg_dig_d = stg_dig;
    stg_dp_d  = stg_dp;
    stg_bnk_d = stg_bnk;
    stg_blk_d = stg_blk;
    stg_lz_d  = stg_lz;
    act_dig_d = act_dig;
    act_dp_d  = act_dp;
    act_bnk_d = act_bnk;
    act_blk_d = act_blk;
    act_lz_d  = act_lz;
    pend_d    = pend;
    if (load) begin
      stg_dig_d = digits_in;
      stg_dp_d  = dp_in;
      stg_bnk_d = blank_in;
      stg_blk_d = blink_in;
      stg_lz_d  = lz_suppress;
      pend_d    = 1'b1;
    end
    if (wrap && (load || pend)) begin
      act_dig_d = stg_dig_d;
      act_dp_d  = stg_dp_d;
      act_bnk_d = stg_bnk_d;
      act_blk_d = stg_blk_d;
      act_lz_d  = stg_lz_d;
    end
    if (wrap) pend_d = 1'b0;
  end

  // Outputs are built from next-state so they line up with the counters.
  always_comb begin
    nib     = '0;
    zeros   = 1'b1;
    sel_z   = 1'b0;
    sel_dp  = 1'b0;
    sel_bnk = 1'b0;
    sel_blk = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      zeros = zeros & (act_dig_d[4*i +: 4] == 4'd0);
      if (idx_d == IW'(i)) begin
        nib     = act_dig_d[4*i +: 4];
        sel_z   = zeros;
        sel_dp  = act_dp_d[i];
        sel_bnk = act_bnk_d[i];
        sel_blk = act_blk_d[i];
      end
    end
  end

  seg_hex_decode #(
    .ACTIVE_LOW(ACTIVE_LOW)
  ) u_dec (
    .nib(nib),
    .seg(dec_seg)
  );

  always_comb begin
    lz_dark   = act_lz_d & sel_z & (idx_d != '0);
    hard_dark = sel_bnk | (sel_blk & hide_d);
    seg_d     = (hard_dark | lz_dark) ? SOFF : dec_seg;
    dp_d      = (sel_dp & ~hard_dark) ? ON : ~ON;
    for (int i = 0; i < N; i++) begin
      an_d[i] = ((idx_d == IW'(i)) && (rcnt_d >= R_GD)) ? ON : ~ON;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rcnt       <= '0;
      idx        <= '0;
      bcnt       <= '0;
      hide       <= 1'b0;
      stg_dig    <= '0;
      stg_dp     <= '0;
      stg_bnk    <= '1;
      stg_blk    <= '0;
      stg_lz     <= 1'b0;
      act_dig    <= '0;
      act_dp     <= '0;
      act_bnk    <= '1;
      act_blk    <= '0;
      act_lz     <= 1'b0;
      pend       <= 1'b0;
      seg_out    <= SOFF;
      dp_out     <= ~ON;
      an_out     <= {N{~ON}};
      frame_done <= 1'b0;
    end else begin
      rcnt       <= rcnt_d;
      idx        <= idx_d;
      bcnt       <= bcnt_d;
      hide       <= hide_d;
      stg_dig    <= stg_dig_d;
      stg_dp     <= stg_dp_d;
      stg_bnk    <= stg_bnk_d;
      stg_blk    <= stg_blk_d;
      stg_lz     <= stg_lz_d;
      act_dig    <= act_dig_d;
      act_dp     <= act_dp_d;
      act_bnk    <= act_bnk_d;
      act_blk    <= act_blk_d;
      act_lz     <= act_lz_d;
      pend       <= pend_d;
      seg_out    <= seg_d;
      dp_out     <= dp_d;
      an_out     <= an_d;
      frame_done <= wrap;
    end
  end

endmodule

// File: tb/tb_seg_scan_driver.sv
// tb_seg_scan_driver: directed + random bench for seg_scan_driver,
// checked every cycle against a time-indexed behavioural model.
module tb_seg_scan_driver;

  localparam int N  = 4;
  localparam int R  = 8;
  localparam int G  = 2;
  localparam int BD = 20;
  localparam int FR = N * R;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic [15:0]   digits_in;
  logic [3:0]    dp_in, blank_in, blink_in;
  logic          lz_suppress, load;
  logic [6:0]    seg_out;
  logic          dp_out;
  logic [3:0]    an_out;
  logic          frame_done;

  seg_scan_driver #(
    .NUM_DIGITS(N),
    .REFRESH_DIV(R),
    .GUARD(G),
    .BLINK_DIV(BD),
    .ACTIVE_LOW(1)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .digits_in(digits_in),
    .dp_in(dp_in),
    .blank_in(blank_in),
    .blink_in(blink_in),
    .lz_suppress(lz_suppress),
    .load(load),
    .seg_out(seg_out),
    .dp_out(dp_out),
    .an_out(an_out),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  logic [6:0] rom [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  // Model: t = clock edges since reset release; everything else follows.
  int          t = 0;
  logic [15:0] m_dig = '0, s_dig = '0;
  logic [3:0]  m_dp = '0, s_dp = '0;
  logic [3:0]  m_bnk = 4'hF, s_bnk = 4'hF;
  logic [3:0]  m_blk = '0, s_blk = '0;
  logic        m_lz = 1'b0, s_lz = 1'b0, m_pend = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      t <= 0;
      m_dig <= '0; s_dig <= '0;
      m_dp <= '0; s_dp <= '0;
      m_bnk <= 4'hF; s_bnk <= 4'hF;
      m_blk <= '0; s_blk <= '0;
      m_lz <= 1'b0; s_lz <= 1'b0;
      m_pend <= 1'b0;
    end else begin
      if (load) begin
        s_dig <= digits_in; s_dp <= dp_in; s_bnk <= blank_in;
        s_blk <= blink_in; s_lz <= lz_suppress;
      end
      if ((t + 1) % FR == 0) begin
        if (load) begin
          m_dig <= digits_in; m_dp <= dp_in; m_bnk <= blank_in;
          m_blk <= blink_in; m_lz <= lz_suppress;
        end else if (m_pend) begin
          m_dig <= s_dig; m_dp <= s_dp; m_bnk <= s_bnk;
          m_blk <= s_blk; m_lz <= s_lz;
        end
        m_pend <= 1'b0;
      end else if (load) begin
        m_pend <= 1'b1;
      end
      t <= t + 1;
    end
  end

  function automatic void model_out(output logic [6:0] es, output logic edp,
                                    output logic [3:0] ean, output logic efd);
    int  r, i;
    bit  hid, hard, lzd;
    r    = t % R;
    i    = (t / R) % N;
    hid  = ((t / BD) % 2) == 1;
    hard = m_bnk[i] || (m_blk[i] && hid);
    lzd  = m_lz && (i != 0) && ((m_dig >> (4 * i)) == 16'd0);
    es   = (hard || lzd) ? 7'h7F : rom[m_dig[4*i +: 4]];
    edp  = hard ? 1'b1 : !m_dp[i];
    ean  = (r < G) ? 4'hF : ~(4'b0001 << i);
    efd  = (t > 0) && (t % FR == 0);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0d)", nm, act, exp, t);
    end
  endtask

  always @(negedge clk) begin : cmp
    logic [6:0] es;
    logic       edp, efd;
    logic [3:0] ean;
    model_out(es, edp, ean, efd);
    chk("m_seg", seg_out, es);
    chk("m_dp", dp_out, edp);
    chk("m_an", an_out, ean);
    chk("m_fd", frame_done, efd);
  end

  task automatic wait_t(input int target);
    int n = 0;
    while (t < target && n < 4000) begin
      @(negedge clk);
      n++;
    end
    chk("reach_t", t, target);
  endtask

  task automatic do_load(input logic [15:0] d, input logic [3:0] dp,
                         input logic [3:0] bk, input logic [3:0] bl,
                         input logic lz);
    digits_in = d; dp_in = dp; blank_in = bk;
    blink_in = bl; lz_suppress = lz; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic first_frame();
    int k;
    for (k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 1) chk("guard_an", an_out, 4'hF);
      if (k == 2) chk("slot0_an", an_out, 4'hE);
      if (k == 10) chk("dark_seg", seg_out, 7'h7F);
      if (frame_done) break;
    end
    chk("first_fd", k, 32);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    digits_in = '0; dp_in = '0; blank_in = '0; blink_in = '0;
    lz_suppress = 1'b0; load = 1'b0;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_seg", seg_out, 7'h7F);
    chk("rst_an", an_out, 4'hF);
    chk("rst_dp", dp_out, 1'b1);
    chk("rst_fd", frame_done, 1'b0);
    rst_n = 1'b1;
    first_frame();

    wait_t(37);
    do_load(16'h1234, 4'h0, 4'h0, 4'h0, 1'b0);
    wait_t(60);
    chk("no_tear", seg_out, 7'h7F);
    wait_t(64);
    chk("apply_fd", frame_done, 1'b1);
    chk("apply_an", an_out, 4'hF);
    chk("apply_seg", seg_out, 7'h19);
    wait_t(66);
    chk("d0_an", an_out, 4'hE);
    chk("d0_seg", seg_out, 7'h19);
    wait_t(74);
    chk("d1_seg", seg_out, 7'h30);
    wait_t(82);
    chk("d2_seg", seg_out, 7'h24);
    wait_t(90);
    chk("d3_seg", seg_out, 7'h79);
    chk("d3_an", an_out, 4'h7);

    wait_t(99);
    do_load(16'h0050, 4'b1000, 4'h0, 4'h0, 1'b1);
    wait_t(130);
    chk("lz_d0", seg_out, 7'h40);
    wait_t(138);
    chk("lz_d1", seg_out, 7'h12);
    wait_t(146);
    chk("lz_d2", seg_out, 7'h7F);
    chk("lz_d2dp", dp_out, 1'b1);
    wait_t(154);
    chk("lz_d3", seg_out, 7'h7F);
    chk("lz_d3dp", dp_out, 1'b0);

    wait_t(169);
    do_load(16'h0000, 4'h0, 4'h0, 4'b0001, 1'b0);
    wait_t(226);
    chk("blk_hide", seg_out, 7'h7F);
    chk("blk_an", an_out, 4'hE);
    wait_t(258);
    chk("blk_show", seg_out, 7'h40);

    wait_t(287);
    do_load(16'hABCD, 4'h0, 4'h0, 4'h0, 1'b0);
    chk("wrap_fd", frame_done, 1'b1);
    wait_t(290);
    chk("wl_d0", seg_out, 7'h21);
    wait_t(298);
    chk("wl_d1", seg_out, 7'h46);
    wait_t(306);
    chk("wl_d2", seg_out, 7'h03);
    wait_t(314);
    chk("wl_d3", seg_out, 7'h08);
    wait_t(322);
    chk("no_pend", seg_out, 7'h21);

    do_load(16'h1111, 4'h0, 4'h0, 4'h0, 1'b0);
    wait_t(340);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_seg", seg_out, 7'h7F);
    chk("ar_an", an_out, 4'hF);
    chk("ar_dp", dp_out, 1'b1);
    chk("ar_fd", frame_done, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    first_frame();

    wait_t(40);
    do_load(16'h1111, 4'h0, 4'h0, 4'h0, 1'b0);
    do_load(16'h2222, 4'h0, 4'h0, 4'h0, 1'b0);
    wait_t(66);
    chk("last_wins", seg_out, 7'h24);

    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 4) == 0) begin
        digits_in   = 16'($urandom) &
                      ($urandom_range(0, 1) ? 16'h00FF : 16'hFFFF);
        dp_in       = 4'($urandom);
        blank_in    = 4'($urandom) & 4'($urandom) & 4'($urandom);
        blink_in    = 4'($urandom);
        lz_suppress = 1'($urandom);
        load        = 1'b1;
      end else begin
        load = 1'b0;
      end
      @(negedge clk);
    end
    load = 1'b0;
    repeat (4) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
